// File: rtl/uart_tx_frame_ctrl_if.sv
// Parallel-side request and serial-side line signals of the UART frame transmitter.
// The upstream producer drives the payload and parity bit, and the framer drives the line.
interface uart_tx_frame_ctrl_if #(
    parameter int Data_width = 8
);
    logic [Data_width-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_bit;
    logic                  tx_out;
    logic                  busy;

    modport master (
        output p_data,
        output data_valid,
        output par_en,
        output par_bit,
        input  tx_out,
        input  busy
    );

    modport slave (
        input  p_data,
        input  data_valid,
        input  par_en,
        input  par_bit,
        output tx_out,
        output busy
    );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framer: start bit, LSB-first payload, optional parity, stop bit.
// One bit period per clock. tx_out and busy are registered and track the state they describe.
//
// state  | meaning
// IDLE   | line high, waiting for data_valid
// START  | start bit (0) on the line
// DATA   | payload bit cnt_q on the line, taken from shreg_q[0]
// PARITY | upstream parity bit on the line
// STOP   | stop bit (1) on the line, last busy cycle
module uart_tx_frame_ctrl #(
    parameter int Data_width = 8
) (
    input logic                  CLK,
    input logic                  RST,
    uart_tx_frame_ctrl_if.slave  tx_if
);

    localparam int CntW = (Data_width > 1) ? $clog2(Data_width) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(Data_width - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q,  state_d;
    logic [Data_width-1:0] shreg_q,  shreg_d;
    logic [CntW-1:0]       cnt_q,    cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  tx_out_q, tx_out_d;
    logic                  busy_q,   busy_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            par_en_q <= par_en_d;
            tx_out_q <= tx_out_d;
            busy_q   <= busy_d;
        end
    end

    // Outputs are computed for the state being entered, so the line is registered
    // yet still shows the start bit in the cycle right after acceptance.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        par_en_d = par_en_q;
        tx_out_d = tx_out_q;
        busy_d   = busy_q;

        unique case (state_q)
            IDLE: begin
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
                if (tx_if.data_valid) begin
                    state_d  = START;
                    shreg_d  = tx_if.p_data;
                    par_en_d = tx_if.par_en;
                    cnt_d    = '0;
                    tx_out_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                state_d  = DATA;
                cnt_d    = '0;
                tx_out_d = shreg_q[0];
            end
            DATA: begin
                if (cnt_q == LastBit) begin
                    if (par_en_q) begin
                        state_d  = PARITY;
                        tx_out_d = tx_if.par_bit;
                    end else begin
                        state_d  = STOP;
                        tx_out_d = 1'b1;
                    end
                end else begin
                    cnt_d    = cnt_q + CntW'(1);
                    shreg_d  = shreg_q >> 1;
                    tx_out_d = shreg_d[0];
                end
            end
            PARITY: begin
                state_d  = STOP;
                tx_out_d = 1'b1;
            end
            STOP: begin
                state_d  = IDLE;
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign tx_if.tx_out = tx_out_q;
    assign tx_if.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: a queue of expected line bits per accepted frame,
// checked every cycle, with directed frames followed by a randomized phase.
module tb_uart_tx_frame_ctrl;

    logic CLK;
    logic RST;

    uart_tx_frame_ctrl_if #(.Data_width(8)) bus ();

    uart_tx_frame_ctrl #(.Data_width(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .tx_if (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int errors   = 0;
    int busy_run = 0;
    int last_run = 0;
    int pb_force = -1;
    bit line_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic pe);
        bus.data_valid = v;
        bus.p_data     = d;
        bus.par_en     = pe;
    endtask

    // One clock: the model sees the inputs as they were before the edge.
    task automatic step();
        logic       v;
        logic       pe;
        logic [7:0] d;
        logic       pb;
        logic       accepted;
        logic       exp_tx;
        logic       exp_busy;
        v        = bus.data_valid;
        pe       = bus.par_en;
        d        = bus.p_data;
        accepted = 1'b0;
        pb       = 1'b0;
        @(posedge CLK);
        if (RST) begin
            if (line_q.size() != 0) begin
                void'(line_q.pop_front());
            end else if (v) begin
                accepted = 1'b1;
                pb = (pb_force >= 0) ? pb_force[0] : 1'($urandom_range(0, 1));
                line_q.push_back(1'b0);
                for (int i = 0; i < 8; i++) line_q.push_back(d[i]);
                if (pe) line_q.push_back(pb);
                line_q.push_back(1'b1);
            end
        end
        #1;
        if (accepted) bus.par_bit = pb;
        exp_tx   = (line_q.size() != 0) ? line_q[0] : 1'b1;
        exp_busy = (line_q.size() != 0);
        check_val("tx_out", 32'(bus.tx_out), 32'(exp_tx));
        check_val("busy", 32'(bus.busy), 32'(exp_busy));
        if (bus.busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
    endtask

    initial begin
        RST = 1'b0;
        bus.par_bit = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        #12;
        check_val("rst_tx_out", 32'(bus.tx_out), 32'd1);
        check_val("rst_busy", 32'(bus.busy), 32'd0);

        // Release with data_valid already high: first edge must accept (0xA5, parity 0).
        @(negedge CLK);
        RST = 1'b1;
        pb_force = 0;
        drive(1'b1, 8'hA5, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0);
        repeat (11) step();
        check_val("a5_busy_len", 32'(last_run), 32'd11);

        // No parity slot.
        drive(1'b1, 8'h3C, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0);
        repeat (10) step();
        check_val("3c_busy_len", 32'(last_run), 32'd10);

        // Back-to-back frames with data_valid held high.
        pb_force = 1;
        drive(1'b1, 8'hFF, 1'b1);
        repeat (36) step();
        drive(1'b0, 8'h00, 1'b0);
        repeat (12) step();
        check_val("ff_busy_len", 32'(last_run), 32'd11);

        // A request during DATA must be dropped.
        pb_force = -1;
        drive(1'b1, 8'h55, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0);
        repeat (3) step();
        drive(1'b1, 8'h00, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0);
        repeat (8) step();
        check_val("55_busy_len", 32'(last_run), 32'd10);

        // Inputs toggling after acceptance must not disturb the frame.
        drive(1'b1, 8'h81, 1'b1);
        step();
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, ~bus.p_data, ~bus.par_en);
            step();
        end
        check_val("81_busy_len", 32'(last_run), 32'd11);

        // Asynchronous reset during data bit 4.
        drive(1'b1, 8'h5A, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0);
        repeat (5) step();
        #2;
        RST = 1'b0;
        #1;
        check_val("async_rst_tx_out", 32'(bus.tx_out), 32'd1);
        check_val("async_rst_busy", 32'(bus.busy), 32'd0);
        line_q.delete();
        busy_run = 0;
        repeat (2) step();
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) step();
        drive(1'b1, 8'hC3, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0);
        repeat (11) step();
        check_val("post_rst_busy_len", 32'(last_run), 32'd11);

        // Randomized phase: sparse and held requests, inputs changing every cycle.
        for (int i = 0; i < 600; i++) begin
            logic v;
            v = (i % 100 < 30) ? 1'b1 : ($urandom_range(0, 3) == 0);
            drive(v, 8'($urandom), 1'($urandom_range(0, 1)));
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
        repeat (14) step();
        check_val("final_idle_queue", 32'(line_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
